// File: rtl/incrementer_pkg.sv
// Shared constants for the ALSU incrementer slice: datapath width and operand-select encodings.
package incrementer_pkg;

  localparam int unsigned INC_WIDTH = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : incrementer_pkg

// File: rtl/incrementer_core.sv
// Pure combinational +1: a ripple chain of half adders whose carry-in is tied to 1.
module incrementer_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic carry;

  always_comb begin
    Sum   = '0;
    carry = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      Sum[i] = In[i] ^ carry;
      carry  = In[i] & carry;
    end
    Cout = carry;
  end

endmodule : incrementer_core

// File: rtl/incrementer_top_module.sv
// Operand-select incrementer: registers (Sel ? B : A) + 1 and its carry-out, async active-high reset.
module incrementer_top_module
  import incrementer_pkg::*;
#(
  parameter int unsigned WIDTH = INC_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] Out,
  output logic             Carry_Out_Inc
);

  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] sum;
  logic             cout;

  always_comb begin
    op = (Sel == SEL_B) ? B : A;
  end

  incrementer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .In   (op),
    .Sum  (sum),
    .Cout (cout)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Out           <= '0;
      Carry_Out_Inc <= 1'b0;
    end else begin
      Out           <= sum;
      Carry_Out_Inc <= cout;
    end
  end

endmodule : incrementer_top_module

// File: tb/tb_incrementer_top_module.sv
// Scoreboard bench for incrementer_top_module: driver queues expected results, monitor checks each edge.
module tb_incrementer_top_module;

  localparam int W = 4;

  logic         Clk;
  logic         Rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Sel;
  logic [W-1:0] Out;
  logic         Carry_Out_Inc;

  int tests = 0;
  int fails = 0;

  logic [W:0] exp_q[$];
  logic [W:0] last_exp;

  incrementer_top_module #(
    .WIDTH (W)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .A             (A),
    .B             (B),
    .Sel           (Sel),
    .Out           (Out),
    .Carry_Out_Inc (Carry_Out_Inc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the selected operand.
  function automatic logic [W:0] model(input int a, input int b, input bit sel);
    int op;
    int r;
    op = sel ? b : a;
    r  = op + 1;
    model = {(r >= (1 << W)) ? 1'b1 : 1'b0, W'(r % (1 << W))};
  endfunction

  task automatic drive(input int a, input int b, input bit sel);
    A   = W'(a);
    B   = W'(b);
    Sel = sel;
    last_exp = model(a, b, sel);
    exp_q.push_back(last_exp);
  endtask

  task automatic cycle(input int a, input int b, input bit sel);
    @(negedge Clk);
    drive(a, b, sel);
  endtask

  // Monitor: every rising edge with a queued expectation yields one comparison.
  initial begin
    logic [W:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", 32'(Out), 32'(e[W-1:0]));
        check("carry", 32'(Carry_Out_Inc), 32'(e[W]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0;
    A   = '0;
    B   = '0;
    Sel = 1'b0;

    // Asynchronous reset before any clock edge.
    #2;
    A   = 4'b0111;
    Sel = 1'b0;
    Rst = 1'b1;
    #1;
    check("reset_out", 32'(Out), 32'd0);
    check("reset_carry", 32'(Carry_Out_Inc), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    check("reset_hold_out", 32'(Out), 32'd0);
    check("reset_hold_carry", 32'(Carry_Out_Inc), 32'd0);

    @(negedge Clk);
    Rst = 1'b0;
    drive(0, 0, 1'b0);
    for (int a = 1; a <= 14; a++) cycle(a, 0, 1'b0);
    cycle(15, 0, 1'b0);

    for (int b = 0; b <= 15; b++) cycle(0, b, 1'b1);

    cycle(15, 3, 1'b1);
    cycle(15, 3, 1'b0);

    // Mid-cycle input change must not reach the outputs before the next edge.
    cycle(5, 9, 1'b0);
    @(posedge Clk);
    #3;
    A = 4'b1111;
    #1;
    check("hold_out", 32'(Out), 32'(last_exp[W-1:0]));
    check("hold_carry", 32'(Carry_Out_Inc), 32'(last_exp[W]));

    for (int n = 0; n < 200; n++) cycle(int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom));

    // Reset asserted mid-cycle clears the outputs at once.
    cycle(15, 15, 1'b1);
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("midreset_out", 32'(Out), 32'd0);
    check("midreset_carry", 32'(Carry_Out_Inc), 32'd0);
    @(posedge Clk);
    #1;
    check("midreset_hold_out", 32'(Out), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    drive(7, 2, 1'b0);
    for (int n = 0; n < 20; n++) cycle(int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom));

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
      @(posedge Clk);
      #2;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_incrementer_top_module
